// File: rtl/uart_pkt_pkg.sv
// Shared constants, FSM encoding and packet byte selection for the UART word packer.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PKT_BYTES         = 6;
  localparam int         IDX_W             = $clog2(PKT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_e;

  // Byte idx of a packet: header, four data bytes MSB first, XOR checksum.
  function automatic logic [7:0] pkt_byte(input logic [7:0]       sync,
                                          input logic [31:0]      word,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      3'd4:    b = word[7:0];
      3'd5:    b = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a registered full flag.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // A push is judged against last cycle's full flag, so a same-cycle pop never frees room.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && !full_q;
    do_pop   = pop && (level_q != '0);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d = (level_d == FULL_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage has no reset; pointers and level define validity, keeping it plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_word_packer.sv
// Buffers 32-bit words and sends each as a 6-byte framed packet to a byte UART.
module uart_word_packer
  import uart_pkt_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   word_valid,
  input  logic [31:0]            word_data,
  output logic                   word_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_count,
  output logic                   pkt_done
);

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  state_e           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       cur_byte;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (word_valid),
    .wdata (word_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign word_ready = !fifo_full;

  // tx_start is decoded in the same cycle SEND sees the transmitter free, which gives
  // the 2-cycle push-to-start latency and 3-cycle byte spacing with an idle UART.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    pkt_done_d = 1'b0;
    fifo_pop   = 1'b0;
    tx_start   = 1'b0;
    cur_byte   = pkt_byte(SYNC_BYTE, hold_q, byte_idx_q);
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        hold_d     = fifo_rdata;
        byte_idx_d = '0;
        state_d    = SEND;
      end
      SEND: if (!tx_busy) begin
        tx_start  = 1'b1;
        tx_data_d = cur_byte;
        state_d   = HOLD;
      end
      HOLD: state_d = WAIT;
      WAIT: if (!tx_busy) begin
        if (byte_idx_q == LAST_IDX) begin
          pkt_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    drop_d = drop_q;
    if (word_valid && !word_ready && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      pkt_done_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      pkt_done_q <= pkt_done_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data    = tx_data_d;
  assign pkt_done   = pkt_done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Self-checking bench: packet-stream reference model plus directed and random traffic.
module tb_uart_word_packer;

  localparam int         DEPTH = 8;
  localparam int         LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_valid = 1'b0;
  logic [31:0]   word_data = '0;
  logic          tx_busy = 1'b0;
  logic          word_ready, tx_start, pkt_done;
  logic [7:0]    tx_data, drop_count;
  logic [LW-1:0] fifo_level;

  uart_word_packer #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .pkt_done   (pkt_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] last_tx = '0;
  int         drops_m = 0;
  int         bytes_sent = 0;
  int         done_cnt = 0;
  int         push_cyc = -1;
  logic [7:0] cap_q[$];
  int         cap_cyc[$];

  // Transmitter model
  int busy_len = 1;
  bit stall = 1'b0;
  int pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stall) tx_busy = 1'b1;
    else if (pending > 0) begin
      tx_busy = 1'b1;
      pending--;
    end else tx_busy = 1'b0;
  end

  // Compare process: every mid-cycle, outputs against the packet-stream model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_tx    = '0;
      drops_m    = 0;
      bytes_sent = 0;
      done_cnt   = 0;
    end else begin
      check("drop_count", drop_count, drops_m);
      if (tx_start) begin
        check("start_while_busy", tx_busy, 1'b0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: got byte 0x%0h, expected no start at t=%0t", tx_data, $time);
        end else check("tx_byte", tx_data, exp_q.pop_front());
        last_tx = tx_data;
        bytes_sent++;
        cap_q.push_back(tx_data);
        cap_cyc.push_back(cyc);
        pending = busy_len;
      end else begin
        check("tx_data_hold", tx_data, last_tx);
      end
      if (pkt_done) begin
        check("pkt_done_boundary", bytes_sent, (done_cnt + 1) * 6);
        done_cnt++;
      end
      if (word_valid && word_ready) begin
        exp_q.push_back(SYNC);
        exp_q.push_back(word_data[31:24]);
        exp_q.push_back(word_data[23:16]);
        exp_q.push_back(word_data[15:8]);
        exp_q.push_back(word_data[7:0]);
        exp_q.push_back(word_data[31:24] ^ word_data[23:16] ^ word_data[15:8] ^ word_data[7:0]);
        push_cyc = cyc;
      end
      if (word_valid && !word_ready && drops_m < 255) drops_m++;
    end
  end

  task automatic push_word(input logic [31:0] w);
    word_valid = 1'b1;
    word_data  = w;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_caps(input string name, input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, cap_q.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_level != '0) && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] lit [6];

    // Reset state
    tick();
    tick();
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_pkt_done", pkt_done, 1'b0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_count", drop_count, 8'h00);
    rst_n = 1'b1;
    tick();
    check("rst_word_ready", word_ready, 1'b1);

    // Single packet, slow transmitter, literal bytes and minimum latency
    busy_len = 10;
    clear_caps();
    base = done_cnt;
    push_word(32'h1234_5678);
    wait_caps("pkt1_bytes_seen", 6, 300);
    lit = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    for (int i = 0; i < 6; i++) check($sformatf("pkt1_byte%0d", i), cap_q[i], lit[i]);
    check("latency_first_start", cap_cyc[0] - push_cyc, 2);
    wait_done("pkt1_done_count", base + 1, 50);
    tick();
    tick();
    check("pkt1_single_done", done_cnt, base + 1);

    // Byte spacing with a one-cycle busy pulse
    busy_len = 1;
    clear_caps();
    push_word($urandom);
    wait_caps("spacing_bytes_seen", 6, 100);
    check("spacing_latency", cap_cyc[0] - push_cyc, 2);
    for (int i = 0; i < 5; i++) check($sformatf("spacing_gap%0d", i), cap_cyc[i+1] - cap_cyc[i], 3);
    wait_done("spacing_done", base + 2, 50);

    // Three words back to back
    busy_len = 3;
    clear_caps();
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      tick();
    end
    word_valid = 1'b0;
    wait_caps("b2b_bytes_seen", 18, 400);
    wait_done("b2b_done_count", base + 5, 100);

    // Overflow while stalled, saturation, then push-while-full with simultaneous pop
    stall = 1'b1;
    tick();
    push_word(32'hDEAD_BEEF);
    tick();
    tick();
    tick();
    check("stall_held_level", fifo_level, 0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      tick();
    end
    word_valid = 1'b0;
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_word_ready", word_ready, 1'b0);
    check("ovf_drop_count", drop_count, 8'd3);
    word_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      word_data = $urandom;
      tick();
    end
    check("drop_saturated", drop_count, 8'd255);
    busy_len = 2;
    stall = 1'b0;
    begin
      int k = 0;
      while (fifo_level == LW'(DEPTH) && k < 300) begin
        word_data = $urandom;
        tick();
        k++;
      end
    end
    word_valid = 1'b0;
    check("full_push_pop_level", fifo_level, DEPTH - 1);
    drain("overflow_drain", 3000);

    // Reset during the third byte of a packet
    tick();
    busy_len = 10;
    clear_caps();
    push_word(32'h0BAD_F00D);
    wait_caps("pre_reset_bytes", 3, 200);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_pkt_done", pkt_done, 1'b0);
    check("midrst_fifo_level", fifo_level, 0);
    check("midrst_drop_count", drop_count, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_word_ready", word_ready, 1'b1);
    clear_caps();
    push_word(32'hCAFE_F00D);
    wait_caps("postrst_bytes", 6, 300);
    check("postrst_first_sync", cap_q[0], 8'hA5);
    check("postrst_byte1", cap_q[1], 8'hCA);
    check("postrst_checksum", cap_q[5], 8'hC9);
    wait_done("postrst_done", 1, 50);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      word_valid = ($urandom_range(0, 3) == 0);
      word_data  = $urandom;
      busy_len   = $urandom_range(0, 4);
      stall      = ($urandom_range(0, 19) == 0);
      tick();
    end
    word_valid = 1'b0;
    stall      = 1'b0;
    busy_len   = 2;
    drain("random_drain", 5000);
    for (int i = 0; i < 40; i++) tick();
    check("final_level", fifo_level, 0);
    check("final_done_count", done_cnt * 6, bytes_sent);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, word FIFO depth (power of 2, ≥2).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, packet header byte.
REQ-003 SHALL have port clk, input, 1, single clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port word_valid, input, 1, upstream word offered this cycle.
REQ-006 SHALL have port word_data, input, 32, upstream word (e.g. frequency measurement).
REQ-007 SHALL have port word_ready, output, 1, FIFO not full; push occurs when word_valid & word_ready.
REQ-008 SHALL have port tx_start, output, 1, one-cycle start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8, byte to transmit, valid while tx_start is high.
REQ-010 SHALL have port tx_busy, input, 1, transmitter busy; rises the cycle after an accepted tx_start.
REQ-011 SHALL have port fifo_level, output, $clog2(DEPTH)+1, words currently stored.
REQ-012 SHALL have port drop_count, output, 8, saturating count of words offered while full.
REQ-013 SHALL have port pkt_done, output, 1, one-cycle pulse after the last byte of a packet completes.

Function
REQ-014 SHALL emit one 6-byte packet per FIFO word: SYNC_BYTE, word_data[31:24], [23:16], [15:8], [7:0], checksum.
REQ-015 SHALL compute checksum as XOR of the four data bytes.
REQ-016 SHALL use FSM states IDLE, SEND, HOLD, WAIT.
REQ-017 IDLE: if FIFO non-empty, pop one word into a 32-bit holding register, clear byte_idx to 0, go to SEND; else stay.
REQ-018 SEND: if tx_busy==0, assert tx_start for exactly one cycle with tx_data = byte[byte_idx], go to HOLD; else stay.
REQ-019 HOLD: one cycle unconditionally (covers tx_busy registration latency), go to WAIT.
REQ-020 WAIT: when tx_busy==0, if byte_idx==5 pulse pkt_done and go to IDLE, else increment byte_idx and go to SEND.
REQ-021 SHALL never assert tx_start while tx_busy==1.
REQ-022 word_ready SHALL be a registered !full; a push while full is rejected even if a pop occurs the same cycle.
REQ-023 Simultaneous push and pop when not full SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL range 0..DEPTH.
REQ-025 drop_count SHALL increment on word_valid & !word_ready and saturate at 255.
REQ-026 tx_data SHALL hold its last value when tx_start is low.
REQ-027 Minimum latency SHALL be 2 cycles from push into empty FIFO (IDLE) to first tx_start.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, FIFO empty, fifo_level 0, word_ready 1 after release, tx_start 0, tx_data 0, pkt_done 0, drop_count 0, byte_idx 0.
REQ-029 Reset mid-packet SHALL abandon the packet; the in-flight UART byte is not tracked; the first tx_start after release SHALL be SYNC_BYTE of a newly pushed word.

Structure
REQ-030 Package uart_pkt_pkg SHALL hold SYNC_BYTE default, PKT_BYTES=6, and the FSM state encoding.
REQ-031 FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level).
REQ-032 FSM, holding register, checksum and drop counter SHALL reside in uart_word_packer.

Verification
REQ-033 Push 32'h12345678, transmitter model with 10-cycle busy -> tx_data sequence A5,12,34,56,78,08; one pkt_done.
REQ-034 Push 3 words back-to-back -> 18 bytes in push order, 3 pkt_done pulses, no tx_start while tx_busy=1.
REQ-035 Hold tx_busy low permanently except 1 cycle after start -> tx_start spacing exactly 3 cycles within a packet.
REQ-036 Push DEPTH+3 words while transmitter stalled -> fifo_level=8, word_ready=0, drop_count=3; 300 drops -> drop_count=255.
REQ-037 Push when full with pop in same cycle -> push rejected, fifo_level=DEPTH-1 next cycle.
REQ-038 Assert rst_n low during byte 3 -> all outputs at reset values immediately; next push yields fresh packet starting A5.
